// File: rtl/pcpu_pkg.sv
// pcpu_pkg: shared definitions for the pcpu core.
//   - Opcode encodings (5-bit, instruction bits [15:11])
//   - Field-slice macros for the instruction word
//   - Debug select_y codes and the IDLE/EXEC state encoding
//   - writes_reg(): which opcodes write gr[r1] at the end of WB
// No ports (package).

`ifndef PCPU_FIELD_MACROS
`define PCPU_FIELD_MACROS
`define PCPU_OP(ir)   ir[15:11]
`define PCPU_R1(ir)   ir[10:8]
`define PCPU_R2(ir)   ir[6:4]
`define PCPU_R3(ir)   ir[2:0]
`define PCPU_VAL4(ir) ir[3:0]
`define PCPU_VAL8(ir) ir[7:0]
`endif

package pcpu_pkg;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    localparam logic [15:0] NOP_IR = 16'h0000;

    localparam logic [3:0] SEL_PC     = 4'd0;
    localparam logic [3:0] SEL_ID_IR  = 4'd1;
    localparam logic [3:0] SEL_REG_A  = 4'd2;
    localparam logic [3:0] SEL_REG_B  = 4'd3;
    localparam logic [3:0] SEL_REG_C  = 4'd4;
    localparam logic [3:0] SEL_REG_C1 = 4'd5;
    localparam logic [3:0] SEL_FLAGS  = 4'd6;
    localparam logic [3:0] SEL_SMDR1  = 4'd7;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Register-file writers: loads, shifts, arithmetic/logic except CMP, LDIH.
    function automatic logic writes_reg(input logic [4:0] op);
        case (op)
            OP_LOAD, OP_SLL, OP_SLA, OP_SRL, OP_SRA,
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_AND, OP_OR, OP_XOR,
            OP_LDIH, OP_ADDC, OP_SUBC: writes_reg = 1'b1;
            default:                   writes_reg = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pcpu_alu.sv
// pcpu_alu: combinational execute unit of the pcpu core.
// Ports:
//   op       in  5   opcode of the instruction in EX
//   a, b     in  16  operands (reg_A, reg_B)
//   cf_in    in  1   current carry flag, consumed by ADDC/SUBC
//   result   out 16  result mod 2^16 (also address/branch target)
//   zf,nf,cf out 1   flags computed from result
//   flags_we out 1   1 when this opcode is allowed to update the flags

module pcpu_alu
    import pcpu_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cf_in,
    output logic [15:0] result,
    output logic        zf,
    output logic        nf,
    output logic        cf,
    output logic        flags_we
);

    // Bit 16 of the wide result is carry-out for adds and borrow for
    // subtracts; logic ops and shifts leave it clear.
    logic [16:0] wide;

    always_comb begin
        wide     = 17'h0;
        flags_we = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_JUMP, OP_JMPR,
            OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC:
                wide = {1'b0, a} + {1'b0, b};
            OP_SLL, OP_SLA: wide = {1'b0, a << b[3:0]};
            OP_SRL:         wide = {1'b0, a >> b[3:0]};
            OP_SRA:         wide = {1'b0, 16'($signed(a) >>> b[3:0])};
            OP_ADD, OP_ADDI, OP_LDIH: begin
                wide     = {1'b0, a} + {1'b0, b};
                flags_we = 1'b1;
            end
            OP_ADDC: begin
                wide     = {1'b0, a} + {1'b0, b} + {16'h0, cf_in};
                flags_we = 1'b1;
            end
            OP_SUB, OP_SUBI, OP_CMP: begin
                wide     = {1'b0, a} - {1'b0, b};
                flags_we = 1'b1;
            end
            OP_SUBC: begin
                wide     = {1'b0, a} - {1'b0, b} - {16'h0, cf_in};
                flags_we = 1'b1;
            end
            OP_AND: begin
                wide     = {1'b0, a & b};
                flags_we = 1'b1;
            end
            OP_OR: begin
                wide     = {1'b0, a | b};
                flags_we = 1'b1;
            end
            OP_XOR: begin
                wide     = {1'b0, a ^ b};
                flags_we = 1'b1;
            end
            default: wide = 17'h0;
        endcase
    end

    assign result = wide[15:0];
    assign zf     = (wide[15:0] == 16'h0);
    assign nf     = wide[15];
    assign cf     = wide[16];

endmodule

// File: rtl/pcpu.sv
// pcpu: 16-bit 5-stage (IF/ID/EX/MEM/WB) pipelined RISC core, gr0..gr7.
// Optional feature macro: PCPU_FORWARD_EN (operand forwarding from EX/MEM/WB).
// Ports:
//   clock, reset      single clock; asynchronous active-high reset
//   enable            global advance, 0 freezes all state
//   start             IDLE->EXEC request
//   i_datain / i_addr instruction memory data / address (= pc)
//   d_datain / d_addr data memory read data / address (= reg_C)
//   d_dataout, d_we   store data (smdr1) and write enable (STORE in MEM)
//   select_y, show_gr debug selector; y is the debug output

module pcpu
    import pcpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [15:0] i_datain,
    input  logic [15:0] d_datain,
    input  logic [3:0]  select_y,
    input  logic        show_gr,
    output logic [7:0]  i_addr,
    output logic [7:0]  d_addr,
    output logic [15:0] d_dataout,
    output logic        d_we,
    output logic [15:0] y
);

    state_t      state;
    logic [7:0]  pc;
    logic [15:0] id_ir, ex_ir, mem_ir, wb_ir;
    logic [15:0] gr [8];
    logic [15:0] reg_a, reg_b, reg_c, reg_c1, smdr, smdr1;
    logic        zf, nf, cf;

    logic [4:0]  id_op, ex_op, mem_op, wb_op;
    logic [15:0] alu_result, mem_result;
    logic        alu_zf, alu_nf, alu_cf, alu_flags_we;
    logic        branch_taken;
    logic [2:0]  src_idx [3];
    logic [15:0] src_val [3];
    logic [15:0] next_a, next_b, next_smdr;

    assign id_op  = `PCPU_OP(id_ir);
    assign ex_op  = `PCPU_OP(ex_ir);
    assign mem_op = `PCPU_OP(mem_ir);
    assign wb_op  = `PCPU_OP(wb_ir);

    // Later stages only decode op/r1; the rest of each word is carried for
    // uniformity and folded here so it is not reported as dangling.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ex_ir, mem_ir, wb_ir};

    pcpu_alu u_alu (
        .op       (ex_op),
        .a        (reg_a),
        .b        (reg_b),
        .cf_in    (cf),
        .result   (alu_result),
        .zf       (alu_zf),
        .nf       (alu_nf),
        .cf       (alu_cf),
        .flags_we (alu_flags_we)
    );

    // Value leaving MEM: load data for LOAD, otherwise the ALU result.
    assign mem_result = (mem_op == OP_LOAD) ? d_datain : reg_c;

    assign src_idx[0] = `PCPU_R1(id_ir);
    assign src_idx[1] = `PCPU_R2(id_ir);
    assign src_idx[2] = `PCPU_R3(id_ir);

    // Register reads for ID. With forwarding, the youngest in-flight writer
    // wins (EX over MEM over WB). A LOAD in EX only has its address, so it
    // is not forwarded from EX; software keeps one slot after a load.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            src_val[i] = gr[src_idx[i]];
`ifdef PCPU_FORWARD_EN
            if (writes_reg(wb_op) && (`PCPU_R1(wb_ir) == src_idx[i]))
                src_val[i] = reg_c1;
            if (writes_reg(mem_op) && (`PCPU_R1(mem_ir) == src_idx[i]))
                src_val[i] = mem_result;
            if (writes_reg(ex_op) && (ex_op != OP_LOAD) && (`PCPU_R1(ex_ir) == src_idx[i]))
                src_val[i] = alu_result;
`endif
        end
    end

    // Operand selection per instruction class.
    always_comb begin
        next_a    = 16'h0;
        next_b    = 16'h0;
        next_smdr = 16'h0;
        case (id_op)
            OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_ADDC, OP_SUBC: begin
                next_a = src_val[1];
                next_b = src_val[2];
            end
            OP_ADDI, OP_SUBI: begin
                next_a = src_val[0];
                next_b = {8'h00, `PCPU_VAL8(id_ir)};
            end
            OP_LDIH: begin
                next_a = src_val[0];
                next_b = {`PCPU_VAL8(id_ir), 8'h00};
            end
            OP_LOAD, OP_STORE: begin
                next_a    = src_val[1];
                next_b    = {12'h000, `PCPU_VAL4(id_ir)};
                next_smdr = src_val[0];
            end
            OP_SLL, OP_SLA, OP_SRL, OP_SRA: begin
                next_a = src_val[1];
                next_b = {12'h000, `PCPU_VAL4(id_ir)};
            end
            OP_JUMP: next_b = {8'h00, `PCPU_VAL8(id_ir)};
            OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: begin
                next_a = src_val[0];
                next_b = {8'h00, `PCPU_VAL8(id_ir)};
            end
            default: ;
        endcase
    end

    // Branches resolve in MEM against the flags currently held.
    always_comb begin
        branch_taken = 1'b0;
        case (mem_op)
            OP_JUMP, OP_JMPR: branch_taken = 1'b1;
            OP_BZ:            branch_taken = zf;
            OP_BNZ:           branch_taken = ~zf;
            OP_BN:            branch_taken = nf;
            OP_BNN:           branch_taken = ~nf;
            OP_BC:            branch_taken = cf;
            OP_BNC:           branch_taken = ~cf;
            default:          branch_taken = 1'b0;
        endcase
    end

    // Run-control FSM: leaves IDLE on start and stays in EXEC until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (enable && (state == IDLE) && start) begin
            state <= EXEC;
        end
    end

    // Whole pipeline advances together when enabled. A taken branch replaces
    // the three younger instructions with NOPs and keeps the squashed EX
    // instruction from touching the flags. HALT in ID holds pc and id_ir.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc     <= 8'h00;
            id_ir  <= NOP_IR;
            ex_ir  <= NOP_IR;
            mem_ir <= NOP_IR;
            wb_ir  <= NOP_IR;
            reg_a  <= 16'h0;
            reg_b  <= 16'h0;
            reg_c  <= 16'h0;
            reg_c1 <= 16'h0;
            smdr   <= 16'h0;
            smdr1  <= 16'h0;
            zf     <= 1'b0;
            nf     <= 1'b0;
            cf     <= 1'b0;
            for (int i = 0; i < 8; i++) gr[i] <= 16'h0;
        end else if (enable) begin
            if (branch_taken) begin
                pc    <= reg_c[7:0];
                id_ir <= NOP_IR;
            end else if (state == IDLE) begin
                id_ir <= NOP_IR;
            end else if (id_op != OP_HALT) begin
                id_ir <= i_datain;
                pc    <= pc + 8'd1;
            end

            ex_ir <= branch_taken ? NOP_IR : id_ir;
            reg_a <= next_a;
            reg_b <= next_b;
            smdr  <= next_smdr;

            mem_ir <= branch_taken ? NOP_IR : ex_ir;
            reg_c  <= alu_result;
            smdr1  <= smdr;
            if (alu_flags_we && !branch_taken) begin
                zf <= alu_zf;
                nf <= alu_nf;
                cf <= alu_cf;
            end

            wb_ir  <= mem_ir;
            reg_c1 <= mem_result;

            if (writes_reg(wb_op)) gr[`PCPU_R1(wb_ir)] <= reg_c1;
        end
    end

    assign i_addr    = pc;
    assign d_addr    = reg_c[7:0];
    assign d_dataout = smdr1;
    assign d_we      = (mem_op == OP_STORE);

    // Debug view of internal state.
    always_comb begin
        y = 16'h0;
        if (show_gr) begin
            y = gr[select_y[2:0]];
        end else begin
            case (select_y)
                SEL_PC:     y = {8'h00, pc};
                SEL_ID_IR:  y = id_ir;
                SEL_REG_A:  y = reg_a;
                SEL_REG_B:  y = reg_b;
                SEL_REG_C:  y = reg_c;
                SEL_REG_C1: y = reg_c1;
                SEL_FLAGS:  y = {13'h0, zf, nf, cf};
                SEL_SMDR1:  y = smdr1;
                default:    y = 16'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_pcpu.sv
// tb_pcpu: self-checking bench for pcpu. Instruction/data memories are
// modelled here; stores are checked against a scoreboard of expected
// (address, data) pairs pushed when each program is set up.

module tb_pcpu;

    localparam logic [4:0] T_HALT  = 5'b00001;
    localparam logic [4:0] T_LOAD  = 5'b00010;
    localparam logic [4:0] T_STORE = 5'b00011;
    localparam logic [4:0] T_ADD   = 5'b01000;
    localparam logic [4:0] T_ADDI  = 5'b01001;
    localparam logic [4:0] T_SUB   = 5'b01010;
    localparam logic [4:0] T_LDIH  = 5'b10000;
    localparam logic [4:0] T_ADDC  = 5'b10001;
    localparam logic [4:0] T_BZ    = 5'b11010;
    localparam logic [4:0] T_BNZ   = 5'b11011;
    localparam logic [15:0] T_NOP_W  = 16'h0000;
    localparam logic [15:0] T_HALT_W = {T_HALT, 11'h000};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic        show_gr = 1'b0;
    logic [3:0]  select_y = 4'd0;
    logic [15:0] i_datain, d_datain, d_dataout, y;
    logic [7:0]  i_addr, d_addr;
    logic        d_we;

    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    logic [23:0] exp_store_q [$];
    int          num_compared = 0;
    int          num_mismatched = 0;
    int          store_count = 0;

    pcpu dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .i_datain  (i_datain),
        .d_datain  (d_datain),
        .select_y  (select_y),
        .show_gr   (show_gr),
        .i_addr    (i_addr),
        .d_addr    (d_addr),
        .d_dataout (d_dataout),
        .d_we      (d_we),
        .y         (y)
    );

    always #5 clock = ~clock;

    assign i_datain = imem[i_addr];
    assign d_datain = dmem[d_addr];

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [4:0] op, input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] r3);
        return {op, r1, 1'b0, r2, 1'b0, r3};
    endfunction

    function automatic logic [15:0] enc_m(input logic [4:0] op, input logic [2:0] r1, input logic [2:0] r2, input logic [3:0] v4);
        return {op, r1, 1'b0, r2, v4};
    endfunction

    function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [2:0] r1, input logic [7:0] v8);
        return {op, r1, v8};
    endfunction

    // Store scoreboard: every d_we cycle pops one expected (addr, data).
    always @(negedge clock) begin
        logic [23:0] exp_entry;
        if (d_we === 1'b1) begin
            store_count++;
            if (exp_store_q.size() > 0) begin
                exp_entry = exp_store_q.pop_front();
                checkOutput("store_addr", {8'h00, d_addr}, {8'h00, exp_entry[23:16]});
                checkOutput("store_data", d_dataout, exp_entry[15:0]);
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = T_NOP_W;
            dmem[i] = 16'h0000;
        end
    endtask

    task automatic load_prog_store();
        clear_mem();
        dmem[0]  = 16'h00AB;
        dmem[1]  = 16'h3C00;
        imem[0]  = enc_m(T_LOAD, 3'd1, 3'd0, 4'd0);
        imem[1]  = enc_m(T_LOAD, 3'd2, 3'd0, 4'd1);
        imem[5]  = enc_r(T_ADD, 3'd3, 3'd1, 3'd2);
        imem[9]  = enc_m(T_STORE, 3'd3, 3'd0, 4'd2);
        imem[10] = T_HALT_W;
    endtask

    // Reset, pulse start for one edge (state -> EXEC), then run 'cycles' edges.
    task automatic applyStimulus(input int cycles);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic check_y(input string tag, input logic sh, input logic [3:0] sel, input logic [15:0] expected);
        show_gr  = sh;
        select_y = sel;
        #1;
        checkOutput(tag, y, expected);
    endtask

    initial begin
        // Load/add/store program
        load_prog_store();
        exp_store_q.push_back({8'h02, 16'h3CAB});
        store_count = 0;
        applyStimulus(30);
        check_y("t1_gr1", 1'b1, 4'd1, 16'h00AB);
        check_y("t1_gr2", 1'b1, 4'd2, 16'h3C00);
        check_y("t1_gr3", 1'b1, 4'd3, 16'h3CAB);
        check_y("t1_pc_halted", 1'b0, 4'd0, 16'h000B);
        check_y("t1_id_ir_halt", 1'b0, 4'd1, T_HALT_W);
        checkOutput("t1_store_count", 16'(store_count), 16'd1);
        checkOutput("t1_sb_drained", 16'(exp_store_q.size()), 16'd0);

        // Reset mid-run
        load_prog_store();
        store_count = 0;
        applyStimulus(4);
        checkOutput("t2_pc_running", {8'h00, i_addr}, 16'h0004);
        reset = 1'b1;
        #1;
        checkOutput("t2_i_addr", {8'h00, i_addr}, 16'h0000);
        checkOutput("t2_d_addr", {8'h00, d_addr}, 16'h0000);
        checkOutput("t2_d_dataout", d_dataout, 16'h0000);
        checkOutput("t2_d_we", {15'h0, d_we}, 16'h0000);
        check_y("t2_gr1_cleared", 1'b1, 4'd1, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("t2_pc_idle", {8'h00, i_addr}, 16'h0000);
        check_y("t2_id_ir_idle", 1'b0, 4'd1, T_NOP_W);
        check_y("t2_flags", 1'b0, 4'd6, 16'h0000);
        checkOutput("t2_store_count", 16'(store_count), 16'd0);

        // Flags and taken branch with squash of three younger instructions
        clear_mem();
        imem[0]    = enc_r(T_SUB, 3'd1, 3'd0, 3'd0);
        imem[1]    = enc_i(T_BZ, 3'd0, 8'h10);
        imem[2]    = enc_i(T_ADDI, 3'd4, 8'h11);
        imem[3]    = enc_i(T_ADDI, 3'd5, 8'h22);
        imem[4]    = enc_i(T_ADDI, 3'd6, 8'h33);
        imem[8'h10] = T_HALT_W;
        applyStimulus(20);
        check_y("t3_pc", 1'b0, 4'd0, 16'h0011);
        check_y("t3_flags_zf", 1'b0, 4'd6, 16'h0004);
        check_y("t3_gr4", 1'b1, 4'd4, 16'h0000);
        check_y("t3_gr5", 1'b1, 4'd5, 16'h0000);
        check_y("t3_gr6", 1'b1, 4'd6, 16'h0000);
        check_y("t3_gr1", 1'b1, 4'd1, 16'h0000);

        // Carry chain: FFFF+1 sets cf/zf, BNZ falls through, ADDC consumes cf
        clear_mem();
        imem[0]     = enc_i(T_LDIH, 3'd1, 8'hFF);
        imem[4]     = enc_i(T_ADDI, 3'd1, 8'hFF);
        imem[8]     = enc_i(T_ADDI, 3'd1, 8'h01);
        imem[9]     = enc_i(T_BNZ, 3'd0, 8'h20);
        imem[10]    = enc_r(T_ADDC, 3'd2, 3'd0, 3'd0);
        imem[11]    = T_HALT_W;
        imem[8'h20] = T_HALT_W;
        applyStimulus(25);
        check_y("t4_gr1_wrap", 1'b1, 4'd1, 16'h0000);
        check_y("t4_gr2_addc", 1'b1, 4'd2, 16'h0001);
        check_y("t4_pc", 1'b0, 4'd0, 16'h000C);
        check_y("t4_flags", 1'b0, 4'd6, 16'h0000);

        // Freeze for three cycles mid-stream, then resume
        load_prog_store();
        exp_store_q.push_back({8'h02, 16'h3CAB});
        store_count = 0;
        applyStimulus(2);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_y("t5_pc_frozen", 1'b0, 4'd0, 16'h0002);
            check_y("t5_id_ir_frozen", 1'b0, 4'd1, enc_m(T_LOAD, 3'd2, 3'd0, 4'd1));
            check_y("t5_gr1_frozen", 1'b1, 4'd1, 16'h0000);
        end
        enable = 1'b1;
        repeat (30) @(negedge clock);
        check_y("t5_gr3", 1'b1, 4'd3, 16'h3CAB);
        check_y("t5_pc_halted", 1'b0, 4'd0, 16'h000B);
        checkOutput("t5_store_count", 16'(store_count), 16'd1);
        checkOutput("t5_sb_drained", 16'(exp_store_q.size()), 16'd0);

        // Debug selector
        check_y("t6_show_gr3", 1'b1, 4'd3, 16'h3CAB);
        check_y("t6_pc_view", 1'b0, 4'd0, 16'h000B);
        check_y("t6_unused_sel", 1'b0, 4'd9, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
